cordic_rot_arbiter: RTL and testbench



---
 rtl/cordic_pkg.sv | 23 ++
 rtl/cordic_rr_pick.sv | 31 +++
 rtl/cordic_rot_arbiter.sv | 204 ++++++++++++++++++++
 tb/tb_cordic_rot_arbiter.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cordic_pkg.sv
// Shared definitions for the CORDIC rotation arbiter: state encoding,
// fixed-point unity for sin/cos requests and default watchdog limit.
package cordic_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_GAP  = 2'd2
  } arb_state_e;

  localparam int unsigned CORDIC_WL_DEF   = 16;
  localparam int unsigned CORDIC_FL_DEF   = 12;
  localparam int unsigned ARB_TIMEOUT_DEF = 64;

  // 1.0 in Q4.12, used as the x operand of a (1,0,-theta) sin/cos request
  localparam logic [CORDIC_WL_DEF-1:0] CORDIC_ONE = 16'(1 << CORDIC_FL_DEF);

  // Index width for a requester count, never narrower than one bit
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/cordic_rr_pick.sv
// Combinational round-robin picker: first set request at or after the
// pointer, wrapping modulo NREQ.
module cordic_rr_pick
  import cordic_pkg::*;
#(
  parameter int unsigned NREQ = 3,
  parameter int unsigned IW   = 2
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [IW-1:0]   i_ptr,
  output logic [IW-1:0]   o_idx,
  output logic            o_hit
);

  int unsigned w_slot;

  // Scan from the farthest offset down so the nearest hit is written last
  always_comb begin
    o_hit  = 1'b0;
    o_idx  = '0;
    w_slot = 0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      w_slot = (32'(i_ptr) + (NREQ - 1 - i)) % NREQ;
      if (i_req[IW'(w_slot)]) begin
        o_hit = 1'b1;
        o_idx = IW'(w_slot);
      end
    end
  end

endmodule

// File: rtl/cordic_rot_arbiter.sv
// Time-shares one cordic_rotation_fixed core among NREQ requesters.
// Optional watchdog on the core handshake: define CORDIC_ARB_TIMEOUT_EN.
module cordic_rot_arbiter
  import cordic_pkg::*;
#(
  parameter int unsigned NREQ           = 3,
  parameter int unsigned N              = 15,
  parameter int unsigned wordLength     = CORDIC_WL_DEF,
  parameter int unsigned fractionLength = CORDIC_FL_DEF,
  parameter int unsigned TIMEOUT_CYC    = ARB_TIMEOUT_DEF
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NREQ-1:0]            req,
  input  logic [NREQ*wordLength-1:0] req_x,
  input  logic [NREQ*wordLength-1:0] req_y,
  input  logic [NREQ*wordLength-1:0] req_theta,
  output logic [NREQ-1:0]            ack,
  output logic [NREQ-1:0]            rsp_valid,
  output logic [wordLength-1:0]      rsp_x,
  output logic [wordLength-1:0]      rsp_y,
  output logic                       rsp_err,
  output logic                       busy,
  output logic [wordLength-1:0]      core_x_in,
  output logic [wordLength-1:0]      core_y_in,
  output logic [wordLength-1:0]      core_theta,
  output logic                       core_valid,
  input  logic                       core_done,
  input  logic [wordLength-1:0]      core_x_out,
  input  logic [wordLength-1:0]      core_y_out
);

  localparam int unsigned IW = idx_w(NREQ);
  localparam int unsigned WL = wordLength;

  // An illegal parameter set leaves the arbiter permanently idle
  localparam bit CFG_OK = (NREQ >= 2) && (NREQ <= 8) &&
                          (fractionLength < wordLength) && (TIMEOUT_CYC > N);

  arb_state_e      r_state, w_state_nxt;
  logic [IW-1:0]   r_ptr, w_ptr_nxt;
  logic [IW-1:0]   r_gid, w_gid_nxt;
  logic [NREQ-1:0] r_ack, w_ack_nxt;
  logic [NREQ-1:0] r_rsp_valid, w_rsp_valid_nxt;
  logic [WL-1:0]   r_rsp_x, w_rsp_x_nxt;
  logic [WL-1:0]   r_rsp_y, w_rsp_y_nxt;
  logic            r_rsp_err, w_rsp_err_nxt;
  logic            r_busy, w_busy_nxt;
  logic [WL-1:0]   r_core_x, w_core_x_nxt;
  logic [WL-1:0]   r_core_y, w_core_y_nxt;
  logic [WL-1:0]   r_core_th, w_core_th_nxt;
  logic            r_core_valid, w_core_valid_nxt;

  logic [IW-1:0]   w_idx;
  logic            w_hit;
  logic            w_go;
  logic [IW-1:0]   w_ptr_adv;
  logic            w_timeout;

  cordic_rr_pick #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_pick (
    .i_req (req),
    .i_ptr (r_ptr),
    .o_idx (w_idx),
    .o_hit (w_hit)
  );

  assign w_go      = w_hit & CFG_OK;
  assign w_ptr_adv = (r_gid == IW'(NREQ - 1)) ? '0 : r_gid + IW'(1);

`ifdef CORDIC_ARB_TIMEOUT_EN
  localparam int unsigned CW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

  logic [CW-1:0] r_cnt, w_cnt_nxt;

  assign w_timeout = (r_cnt == CW'(TIMEOUT_CYC - 1));

  // Watchdog: cleared on grant, counts every BUSY cycle
  always_comb begin
    w_cnt_nxt = r_cnt;
    if (r_state == ST_IDLE && w_go) begin
      w_cnt_nxt = '0;
    end else if (r_state == ST_BUSY) begin
      w_cnt_nxt = r_cnt + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= w_cnt_nxt;
    end
  end
`else
  assign w_timeout = 1'b0;
`endif

  // Next-state and next-output logic
  always_comb begin
    w_state_nxt      = r_state;
    w_ptr_nxt        = r_ptr;
    w_gid_nxt        = r_gid;
    w_ack_nxt        = '0;
    w_rsp_valid_nxt  = '0;
    w_rsp_x_nxt      = r_rsp_x;
    w_rsp_y_nxt      = r_rsp_y;
    w_rsp_err_nxt    = r_rsp_err;
    w_core_x_nxt     = r_core_x;
    w_core_y_nxt     = r_core_y;
    w_core_th_nxt    = r_core_th;
    w_core_valid_nxt = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (w_go) begin
          w_core_x_nxt     = req_x[32'(w_idx) * WL +: WL];
          w_core_y_nxt     = req_y[32'(w_idx) * WL +: WL];
          w_core_th_nxt    = req_theta[32'(w_idx) * WL +: WL];
          w_gid_nxt        = w_idx;
          w_ack_nxt[w_idx] = 1'b1;
          w_core_valid_nxt = 1'b1;
          w_state_nxt      = ST_BUSY;
        end
      end
      ST_BUSY: begin
        w_core_valid_nxt = 1'b1;
        // A done arriving with the timeout wins
        if (core_done) begin
          w_rsp_x_nxt            = core_x_out;
          w_rsp_y_nxt            = core_y_out;
          w_rsp_err_nxt          = 1'b0;
          w_rsp_valid_nxt[r_gid] = 1'b1;
          w_core_valid_nxt       = 1'b0;
          w_ptr_nxt              = w_ptr_adv;
          w_state_nxt            = ST_GAP;
        end else if (w_timeout) begin
          w_rsp_x_nxt            = '0;
          w_rsp_y_nxt            = '0;
          w_rsp_err_nxt          = 1'b1;
          w_rsp_valid_nxt[r_gid] = 1'b1;
          w_core_valid_nxt       = 1'b0;
          w_ptr_nxt              = w_ptr_adv;
          w_state_nxt            = ST_GAP;
        end
      end
      ST_GAP: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase

    w_busy_nxt = (w_state_nxt != ST_IDLE);
  end

  // State and output registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= ST_IDLE;
      r_ptr        <= '0;
      r_gid        <= '0;
      r_ack        <= '0;
      r_rsp_valid  <= '0;
      r_rsp_x      <= '0;
      r_rsp_y      <= '0;
      r_rsp_err    <= 1'b0;
      r_busy       <= 1'b0;
      r_core_x     <= '0;
      r_core_y     <= '0;
      r_core_th    <= '0;
      r_core_valid <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_ptr        <= w_ptr_nxt;
      r_gid        <= w_gid_nxt;
      r_ack        <= w_ack_nxt;
      r_rsp_valid  <= w_rsp_valid_nxt;
      r_rsp_x      <= w_rsp_x_nxt;
      r_rsp_y      <= w_rsp_y_nxt;
      r_rsp_err    <= w_rsp_err_nxt;
      r_busy       <= w_busy_nxt;
      r_core_x     <= w_core_x_nxt;
      r_core_y     <= w_core_y_nxt;
      r_core_th    <= w_core_th_nxt;
      r_core_valid <= w_core_valid_nxt;
    end
  end

  assign ack        = r_ack;
  assign rsp_valid  = r_rsp_valid;
  assign rsp_x      = r_rsp_x;
  assign rsp_y      = r_rsp_y;
  assign rsp_err    = r_rsp_err;
  assign busy       = r_busy;
  assign core_x_in  = r_core_x;
  assign core_y_in  = r_core_y;
  assign core_theta = r_core_th;
  assign core_valid = r_core_valid;

endmodule

// File: tb/tb_cordic_rot_arbiter.sv
// Directed bench for cordic_rot_arbiter with a fixed-latency stub core.
module tb_cordic_rot_arbiter;
  import cordic_pkg::*;

  localparam int unsigned NREQ = 3;
  localparam int unsigned WL   = 16;
  localparam int unsigned LAT  = 3;
  localparam int unsigned TMO  = 64;

  logic clk   = 1'b0;
  logic reset = 1'b0;

  logic [NREQ-1:0]    req;
  logic [WL-1:0]      x_op [NREQ];
  logic [WL-1:0]      y_op [NREQ];
  logic [WL-1:0]      th_op[NREQ];
  logic [NREQ*WL-1:0] req_x, req_y, req_theta;

  logic [NREQ-1:0] ack, rsp_valid;
  logic [WL-1:0]   rsp_x, rsp_y;
  logic            rsp_err, busy;
  logic [WL-1:0]   core_x_in, core_y_in, core_theta;
  logic            core_valid;
  logic            core_done;
  logic [WL-1:0]   core_x_out, core_y_out;

  logic            stub_hang, stub_fixed;
  logic [WL-1:0]   fix_x, fix_y;
  int unsigned     stub_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  assign req_x     = {x_op[2], x_op[1], x_op[0]};
  assign req_y     = {y_op[2], y_op[1], y_op[0]};
  assign req_theta = {th_op[2], th_op[1], th_op[0]};

  always #5 clk = ~clk;

  cordic_rot_arbiter #(
    .NREQ           (NREQ),
    .N              (15),
    .wordLength     (WL),
    .fractionLength (12),
    .TIMEOUT_CYC    (TMO)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .req        (req),
    .req_x      (req_x),
    .req_y      (req_y),
    .req_theta  (req_theta),
    .ack        (ack),
    .rsp_valid  (rsp_valid),
    .rsp_x      (rsp_x),
    .rsp_y      (rsp_y),
    .rsp_err    (rsp_err),
    .busy       (busy),
    .core_x_in  (core_x_in),
    .core_y_in  (core_y_in),
    .core_theta (core_theta),
    .core_valid (core_valid),
    .core_done  (core_done),
    .core_x_out (core_x_out),
    .core_y_out (core_y_out)
  );

  // Stub core: done pulses LAT cycles after valid rises, echoes x+1/y+1 or fixed values
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      core_done  <= 1'b0;
      stub_cnt   <= 0;
      core_x_out <= '0;
      core_y_out <= '0;
    end else begin
      core_done <= 1'b0;
      if (!core_valid || stub_hang) begin
        stub_cnt <= 0;
      end else if (stub_cnt == LAT - 1) begin
        core_done  <= 1'b1;
        stub_cnt   <= LAT;
        core_x_out <= stub_fixed ? fix_x : 16'(core_x_in + 16'd1);
        core_y_out <= stub_fixed ? fix_y : 16'(core_y_in + 16'd1);
      end else if (stub_cnt < LAT) begin
        stub_cnt <= stub_cnt + 1;
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Wait (bounded) for an ack; check winner and latched operands
  task automatic wait_ack(input int k, input string tag);
    int n;
    logic [NREQ-1:0] e;
    n = 0;
    e = '0;
    e[k] = 1'b1;
    while (ack == '0 && n < 16) begin
      tick();
      n++;
    end
    check({tag, "_ack"}, 64'(ack), 64'(e));
    check({tag, "_cx"}, 64'(core_x_in), 64'(x_op[k]));
    check({tag, "_cy"}, 64'(core_y_in), 64'(y_op[k]));
    check({tag, "_cth"}, 64'(core_theta), 64'(th_op[k]));
    check({tag, "_cv"}, 64'(core_valid), 64'(1));
  endtask

  // Called at the ack cycle: valid held, result after LAT+1 cycles, then a GAP
  task automatic wait_rsp(input int k, input string tag);
    int n;
    logic held;
    logic [NREQ-1:0] e;
    logic [WL-1:0] ex, ey;
    n = 0;
    held = 1'b1;
    e = '0;
    e[k] = 1'b1;
    ex = stub_fixed ? fix_x : 16'(x_op[k] + 16'd1);
    ey = stub_fixed ? fix_y : 16'(y_op[k] + 16'd1);
    while (rsp_valid == '0 && n < 16) begin
      if (core_valid !== 1'b1) held = 1'b0;
      tick();
      n++;
    end
    check({tag, "_hold"}, 64'(held), 64'(1));
    check({tag, "_lat"}, 64'(n), 64'(LAT + 1));
    check({tag, "_rv"}, 64'(rsp_valid), 64'(e));
    check({tag, "_rx"}, 64'(rsp_x), 64'(ex));
    check({tag, "_ry"}, 64'(rsp_y), 64'(ey));
    check({tag, "_err"}, 64'(rsp_err), 64'(0));
    check({tag, "_cv0"}, 64'(core_valid), 64'(0));
    tick();
    check({tag, "_pulse"}, 64'(rsp_valid), 64'(0));
    check({tag, "_gap"}, 64'(core_valid), 64'(0));
  endtask

  initial begin
    int n;
    int ord[4];
    logic quiet;
    ord = '{0, 1, 2, 0};
    req = '0;
    stub_hang = 1'b0;
    stub_fixed = 1'b0;
    fix_x = 16'h0DDB;
    fix_y = 16'h0800;
    x_op = '{16'h0100, 16'h0200, 16'h0300};
    y_op = '{16'h0A00, 16'h0B00, 16'h0C00};
    th_op = '{16'h0011, 16'h0022, 16'h0033};

    // Reset state
    repeat (3) tick();
    check("rst_outs", 64'({ack, rsp_valid, rsp_x, rsp_y, rsp_err, busy, core_valid}), 64'(0));
    check("rst_core_ops", 64'({core_x_in, core_y_in, core_theta}), 64'(0));
    reset = 1'b1;
    tick();
    check("idle_busy", 64'(busy), 64'(0));

    // All three requesters held: grants 0,1,2,0
    req = 3'b111;
    for (int i = 0; i < 4; i++) begin
      wait_ack(ord[i], "rr");
      check("rr_busy", 64'(busy), 64'(1));
      if (i == 3) req = '0;
      wait_rsp(ord[i], "rr");
    end

    // Single sin/cos-style request through a core returning fixed results
    stub_fixed = 1'b1;
    x_op[0] = CORDIC_ONE;
    y_op[0] = 16'h0000;
    th_op[0] = 16'h0861;
    req = 3'b001;
    wait_ack(0, "one");
    req = '0;
    wait_rsp(0, "one");
    stub_fixed = 1'b0;
    x_op[0] = 16'h0100;
    y_op[0] = 16'h0A00;
    th_op[0] = 16'h0011;

    // req[2] rises while job 0 is busy and req[0] stays high: 2 before 0
    req = 3'b001;
    wait_ack(0, "late");
    req[2] = 1'b1;
    wait_rsp(0, "late");
    wait_ack(2, "late2");
    req[2] = 1'b0;
    wait_rsp(2, "late2");
    wait_ack(0, "late0");
    req[0] = 1'b0;
    wait_rsp(0, "late0");

    // core_done and a new request in the same cycle
    req = 3'b010;
    wait_ack(1, "sim");
    req = '0;
    n = 0;
    while (core_done !== 1'b1 && n < 16) begin
      tick();
      n++;
    end
    check("sim_done_seen", 64'(core_done), 64'(1));
    req = 3'b100;
    tick();
    check("sim_rv", 64'(rsp_valid), 64'(3'b010));
    check("sim_rx", 64'(rsp_x), 64'(16'h0201));
    check("sim_ack_gap", 64'(ack), 64'(0));
    tick();
    check("sim_ack_idle", 64'(ack), 64'(0));
    tick();
    check("sim_ack2", 64'(ack), 64'(3'b100));
    wait_ack(2, "sim2");
    req = '0;
    wait_rsp(2, "sim2");

    // Move the pointer to 2, then reset in the middle of a job
    req = 3'b010;
    wait_ack(1, "pre");
    req = '0;
    wait_rsp(1, "pre");
    req = 3'b001;
    wait_ack(0, "mid");
    req = '0;
    tick();
    reset = 1'b0;
    #1;
    check("mid_rst_outs", 64'({ack, rsp_valid, rsp_x, rsp_y, rsp_err, busy, core_valid}), 64'(0));
    check("mid_rst_ops", 64'({core_x_in, core_y_in, core_theta}), 64'(0));
    tick();
    tick();
    reset = 1'b1;
    quiet = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (rsp_valid != '0 || busy !== 1'b0) quiet = 1'b0;
    end
    check("mid_no_rsp", 64'(quiet), 64'(1));
    req = 3'b110;
    wait_ack(1, "post");
    req[1] = 1'b0;
    wait_rsp(1, "post");
    wait_ack(2, "post2");
    req[2] = 1'b0;
    wait_rsp(2, "post2");

`ifdef CORDIC_ARB_TIMEOUT_EN
    // Core never finishes: watchdog response TMO cycles after ack
    stub_hang = 1'b1;
    req = 3'b001;
    wait_ack(0, "tmo");
    req = '0;
    n = 0;
    while (rsp_valid == '0 && n < 200) begin
      tick();
      n++;
    end
    check("tmo_lat", 64'(n), 64'(TMO));
    check("tmo_rv", 64'(rsp_valid), 64'(3'b001));
    check("tmo_err", 64'(rsp_err), 64'(1));
    check("tmo_rxy", 64'({rsp_x, rsp_y}), 64'(0));
    stub_hang = 1'b0;
    tick();
    req = 3'b010;
    wait_ack(1, "tmo_next");
    req = '0;
    wait_rsp(1, "tmo_next");
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
